// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared execute-stage constants, op modes and multi-cycle state type
//
// Contents:
//   XLEN                      datapath width
//   OPM_MUL/OPM_DIV/OPM_REM   decoder op modes routed to the multi-cycle unit
//   mdstate_t                 sequencer state {IDLE, CALC, FIX, DONE}
//   abs_val                   two's-complement magnitude (0x80000000 maps to unsigned 2^31)
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OPM_MUL = 3'd5;
  localparam logic [2:0] OPM_DIV = 3'd6;
  localparam logic [2:0] OPM_REM = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdstate_t;

  // Negating 0x80000000 yields 0x80000000, which read as unsigned is exactly 2^31.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV32M MUL/DIV/REM sequencer with shared shift datapath
//
// Ports:
//   i_clk, i_rst            clock (rising edge), asynchronous active-high reset
//   i_start, i_op_mode      request and op mode (5=MUL, 6=DIV, 7=REM)
//   i_rs1_data, i_rs2_data  multiplicand/dividend, multiplier/divisor
//   i_rd                    destination register, captured at accept
//   i_flush                 abort any in-flight operation
//   o_ready, o_busy         idle indication and pipeline stall
//   o_done                  one-cycle result strobe
//   o_result, o_rd          registered result and destination, held until the next result
module muldiv_seq
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int ITER = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op_mode,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  mdstate_t        state;
  logic [4:0]      cnt;
  logic            setup;     // first CALC cycle: convert DIV/REM operands to magnitudes
  logic [2:0]      op;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] opa;       // MUL: shifting multiplicand; DIV: dividend shifting into quotient
  logic [XLEN-1:0] opb;       // MUL: shifting multiplier;   DIV: divisor magnitude
  logic [XLEN:0]   acc;       // MUL: product (low XLEN bits); DIV: partial remainder
  logic            neg_q;
  logic            neg_r;

  logic            is_md;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);

  assign is_md = (i_op_mode == OPM_MUL) || (i_op_mode == OPM_DIV) || (i_op_mode == OPM_REM);

  // Restoring step: shift the next dividend bit into the remainder and trial-subtract.
  // A clear top bit of the difference means the subtraction did not borrow.
  always_comb begin
    div_shift = {acc[XLEN-1:0], opa[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      setup    <= 1'b0;
      op       <= '0;
      rd_q     <= '0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      o_result <= '0;
      o_rd     <= '0;
    end else if (i_flush && state != IDLE) begin
      state <= IDLE;
      setup <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start && is_md) begin
            op   <= i_op_mode;
            rd_q <= i_rd;
            opa  <= i_rs1_data;
            opb  <= i_rs2_data;
            acc  <= '0;
            cnt  <= '0;
            if (i_op_mode != OPM_MUL && i_rs2_data == '0) begin
              // Divide by zero bypasses the datapath: all-ones quotient, dividend remainder.
              o_result <= (i_op_mode == OPM_DIV) ? '1 : i_rs1_data;
              o_rd     <= i_rd;
              state    <= DONE;
            end else begin
              setup <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (setup) begin
            setup <= 1'b0;
            if (op != OPM_MUL) begin
              neg_q <= opa[XLEN-1] ^ opb[XLEN-1];
              neg_r <= opa[XLEN-1];
              opa   <= abs_val(opa);
              opb   <= abs_val(opb);
            end
          end else begin
            if (op == OPM_MUL) begin
              acc <= {1'b0, acc[XLEN-1:0] + (opb[0] ? opa : '0)};
              opa <= {opa[XLEN-2:0], 1'b0};
              opb <= {1'b0, opb[XLEN-1:1]};
            end else if (!div_diff[XLEN+1]) begin
              acc <= div_diff[XLEN:0];
              opa <= {opa[XLEN-2:0], 1'b1};
            end else begin
              acc <= div_shift;
              opa <= {opa[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + 5'd1;
            if (cnt == 5'(ITER - 1)) state <= FIX;
          end
        end
        FIX: begin
          if (op == OPM_MUL)      o_result <= acc[XLEN-1:0];
          else if (op == OPM_DIV) o_result <= neg_q ? (~opa + 1'b1) : opa;
          else                    o_result <= neg_r ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
          o_rd  <= rd_q;
          state <= DONE;
        end
        default: state <= IDLE;  // DONE
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op_mode = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        ready, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_op_mode  (op_mode),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_rd       (rd_in),
    .i_flush    (flush),
    .o_ready    (ready),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_rd       (rd_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; op_mode = op; rs1 = a; rs2 = b; rd_in = rd;
    @(posedge clk);
    #1;
    start = 1'b0; op_mode = 3'd0;
  endtask

  // Issue one operation and time o_done from the accept edge (edge 0).
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    logic [31:0] res;
    logic [4:0]  rdo;
    lat = -1; res = '0; rdo = '0;
    issue(op, a, b, rd);
    for (int e = 0; e < 60 && lat < 0; e++) begin
      @(negedge clk);
      if (done) begin
        lat = e; res = result; rdo = rd_out;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, res, exp_res);
    check({tag, "_rd"}, {27'd0, rdo}, {27'd0, rd});
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
    check({tag, "_result_held"}, result, exp_res);
  endtask

  initial begin
    int ndone;
    logic [31:0] last_res;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;

    run_op("mul_7x6",   3'd5, 32'd7, 32'd6, 5'd11, 32'h0000_002A, 34);
    run_op("mul_m1xm1", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0000_0001, 34);
    run_op("div_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",  3'd7, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFF, 34);
    run_op("div_100_m7", 3'd6, 32'd100, 32'hFFFF_FFF9, 5'd15, 32'hFFFF_FFF2, 34);
    run_op("rem_100_m7", 3'd7, 32'd100, 32'hFFFF_FFF9, 5'd16, 32'h0000_0002, 34);
    run_op("div_5_0",   3'd6, 32'd5, 32'd0, 5'd17, 32'hFFFF_FFFF, 0);
    run_op("rem_5_0",   3'd7, 32'd5, 32'd0, 5'd18, 32'h0000_0005, 0);
    run_op("div_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 34);
    run_op("rem_ovf",   3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0000_0000, 34);

    // Unsupported op mode is ignored
    issue(3'd3, 32'd1, 32'd2, 5'd1);
    check("badop_ready", {31'd0, ready}, 32'd1);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("badop_no_done", 32'(ndone), 32'd0);

    // Flush at edge 10
    issue(3'd5, 32'd7, 32'd6, 5'd2);
    for (int e = 0; e < 10; e++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", {31'd0, ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("flush_no_done", 32'(ndone), 32'd0);

    // Start while busy is ignored
    issue(3'd5, 32'd3, 32'd4, 5'd9);
    repeat (5) @(negedge clk);
    start = 1'b1; op_mode = 3'd5; rs1 = 32'd9; rs2 = 32'd9; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0; op_mode = 3'd0;
    ndone = 0; last_res = '0;
    repeat (80) begin
      @(negedge clk);
      if (done) begin
        ndone++; last_res = result;
      end
    end
    check("busy_start_one_done", 32'(ndone), 32'd1);
    check("busy_start_result", last_res, 32'd12);
    check("busy_start_rd", {27'd0, rd_out}, 32'd9);

    // Asynchronous reset mid-DIV
    issue(3'd6, 32'd100, 32'd7, 5'd4);
    repeat (20) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", {31'd0, ready}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_result", result, 32'd0);
    check("async_rst_rd", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("rem_17_5", 3'd7, 32'd17, 32'd5, 5'd21, 32'h0000_0002, 34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
